mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator_if.sv | 27 ++
 rtl/mac_accumulator.sv | 116 +++++++++++
 tb/tb_mac_accumulator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_if.sv
// Valid/ready bundle between the multiplier, the accumulator stage and its result consumer.
interface mac_accumulator_if #(
  parameter int unsigned PRODUCT_WIDTH = 4,
  parameter int unsigned ACC_WIDTH     = 12,
  parameter int unsigned COUNT_WIDTH   = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [PRODUCT_WIDTH-1:0] in_product;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_WIDTH-1:0]     out_sum;
  logic [COUNT_WIDTH-1:0]   out_count;
  logic                     out_overflow;
  logic                     busy;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow, busy
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow, busy
  );
endinterface

// File: rtl/mac_accumulator.sv
// Frame accumulator behind the multiplier: sums unsigned products and hands the
// sum, product count and sticky overflow flag to the consumer on in_last.
module mac_accumulator #(
  parameter int unsigned PRODUCT_WIDTH = 4,
  parameter int unsigned ACC_WIDTH     = 12,
  parameter int unsigned COUNT_WIDTH   = 8,
  parameter bit          SATURATE      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  mac_accumulator_if.slave  bus
);

  localparam int unsigned SUM_W = ACC_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  if (ACC_WIDTH < PRODUCT_WIDTH) begin : g_bad_width
    $error("ACC_WIDTH must be >= PRODUCT_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;

  logic [PRODUCT_WIDTH-1:0] product_c;
  logic [SUM_W-1:0]         sum_c;
  logic                     in_ready_c;
  logic                     in_xfer_c;
  logic                     out_xfer_c;

  assign product_c  = bus.in_product;
  assign in_ready_c = (state_q != DONE);
  assign in_xfer_c  = bus.in_valid && in_ready_c;
  assign out_xfer_c = out_valid_q && bus.out_ready;

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath update; the extra sum bit is the carry out of the accumulator.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    sum_c   = SUM_W'(acc_q) + SUM_W'(product_c);

    unique case (state_q)
      IDLE: begin
        if (in_xfer_c) begin
          acc_d   = ACC_WIDTH'(product_c);
          count_d = COUNT_WIDTH'(1);
          ovf_d   = 1'b0;
          state_d = bus.in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer_c) begin
          if (sum_c[ACC_WIDTH]) begin
            ovf_d = 1'b1;
            acc_d = SATURATE ? {ACC_WIDTH{1'b1}} : sum_c[ACC_WIDTH-1:0];
          end else begin
            acc_d = sum_c[ACC_WIDTH-1:0];
          end
          if (count_q != CNT_MAX) begin
            count_d = count_q + COUNT_WIDTH'(1);
          end
          if (bus.in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_xfer_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = acc_q;
  assign bus.out_count    = count_q;
  assign bus.out_overflow = ovf_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench: four accumulator configurations share one input stream; a
// reference model predicts each frame result and a per-instance monitor checks it.
module tb_mac_accumulator;

  localparam int NI = 4;
  localparam int unsigned AW_T  [NI] = '{12, 4, 4, 12};
  localparam int unsigned CW_T  [NI] = '{8, 8, 8, 2};
  localparam bit          SAT_T [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

  typedef struct {
    int sum;
    int cnt;
    int ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_product;
  logic       in_last;
  logic       out_ready;

  logic        ov_w   [NI];
  logic        rdy_w  [NI];
  logic        busy_w [NI];
  logic [31:0] sum_w  [NI];
  logic [31:0] cnt_w  [NI];
  logic [31:0] ovf_w  [NI];

  exp_t exp_q [NI][$];
  int   m_sum [NI];
  int   m_cnt [NI];
  int   m_ovf [NI];
  bit   m_first;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mac_accumulator_if #(.PRODUCT_WIDTH(4), .ACC_WIDTH(AW_T[g]), .COUNT_WIDTH(CW_T[g])) bus ();

    assign bus.in_valid   = in_valid;
    assign bus.in_product = in_product;
    assign bus.in_last    = in_last;
    assign bus.out_ready  = out_ready;

    mac_accumulator #(
      .PRODUCT_WIDTH(4),
      .ACC_WIDTH    (AW_T[g]),
      .COUNT_WIDTH  (CW_T[g]),
      .SATURATE     (SAT_T[g])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign ov_w[g]   = bus.out_valid;
    assign rdy_w[g]  = bus.in_ready;
    assign busy_w[g] = bus.busy;
    assign sum_w[g]  = 32'(bus.out_sum);
    assign cnt_w[g]  = 32'(bus.out_count);
    assign ovf_w[g]  = 32'(bus.out_overflow);

    exp_t e;

    // Output transfer happens at the coming rising edge: compare against the oldest prediction.
    always @(negedge clk) begin
      if (!rst && bus.out_valid && out_ready) begin
        if (exp_q[g].size() == 0) begin
          expect_eq($sformatf("unexpected_result[%0d]", g), 32'd1, 32'd0);
        end else begin
          e = exp_q[g].pop_front();
          expect_eq($sformatf("sum[%0d]", g), 32'(bus.out_sum), 32'(e.sum));
          expect_eq($sformatf("count[%0d]", g), 32'(bus.out_count), 32'(e.cnt));
          expect_eq($sformatf("ovf[%0d]", g), 32'(bus.out_overflow), 32'(e.ovf));
        end
      end
    end
  end

  function automatic void model_accept(input int prod, input bit last);
    for (int k = 0; k < NI; k++) begin
      int amax = (1 << AW_T[k]) - 1;
      int cmax = (1 << CW_T[k]) - 1;
      if (m_first) begin
        m_sum[k] = prod;
        m_cnt[k] = 1;
        m_ovf[k] = 0;
      end else begin
        m_sum[k] = m_sum[k] + prod;
        if (m_sum[k] > amax) begin
          m_ovf[k] = 1;
          m_sum[k] = SAT_T[k] ? amax : (m_sum[k] & amax);
        end
        m_cnt[k] = (m_cnt[k] < cmax) ? m_cnt[k] + 1 : cmax;
      end
      if (last) exp_q[k].push_back('{sum: m_sum[k], cnt: m_cnt[k], ovf: m_ovf[k]});
    end
    m_first = last;
  endfunction

  // Present one product and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input int prod, input bit last);
    bit ok = 1'b0;
    in_valid   = 1'b1;
    in_product = 4'(prod);
    in_last    = last;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (rdy_w[0]) begin
        ok = 1'b1;
        @(posedge clk);
        model_accept(prod, last);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) expect_eq("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok && last) expect_eq("latency_out_valid", 32'(ov_w[0]), 32'd1);
  endtask

  // Input bubbles: the accumulator must not move while nothing is transferred.
  task automatic idle(input int n);
    logic [31:0] s0 = sum_w[0];
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      expect_eq("bubble_hold", sum_w[0], s0);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (ov_w[0] && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    expect_eq("drain_idle", 32'(busy_w[0]), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < NI; k++) begin
      expect_eq($sformatf("%s_valid[%0d]", tag, k), 32'(ov_w[k]), 32'd0);
      expect_eq($sformatf("%s_busy[%0d]", tag, k), 32'(busy_w[k]), 32'd0);
      expect_eq($sformatf("%s_sum[%0d]", tag, k), sum_w[k], 32'd0);
      expect_eq($sformatf("%s_cnt[%0d]", tag, k), cnt_w[k], 32'd0);
      expect_eq($sformatf("%s_ovf[%0d]", tag, k), ovf_w[k], 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hs, hc;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_product = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    m_first    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_eq("ready_after_reset", 32'(rdy_w[0]), 32'd1);

    // Contiguous frame, then idle the cycle after the result leaves.
    send(3, 0); send(6, 0); send(9, 0); send(1, 1);
    @(posedge clk);
    #1;
    expect_eq("idle_after_result", 32'(busy_w[0]), 32'd0);
    expect_eq("valid_drops", 32'(ov_w[0]), 32'd0);

    // Single-product frame, then a frame with bubbles.
    send(9, 1);
    send(2, 0);
    idle(2);
    send(4, 1);
    drain();

    // Overflow frame followed by a clean frame that must clear the flag.
    send(9, 0); send(9, 1);
    send(1, 1);
    drain();

    // Backpressure: result held while ignored products are presented.
    out_ready = 1'b0;
    send(5, 0); send(7, 1);
    hs = sum_w[0];
    hc = cnt_w[0];
    for (int i = 0; i < 5; i++) begin
      in_valid   = 1'b1;
      in_product = 4'($urandom_range(0, 15));
      in_last    = 1'($urandom_range(0, 1));
      @(negedge clk);
      expect_eq("bp_in_ready", 32'(rdy_w[0]), 32'd0);
      expect_eq("bp_valid", 32'(ov_w[0]), 32'd1);
      expect_eq("bp_sum", sum_w[0], hs);
      expect_eq("bp_cnt", cnt_w[0], hc);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_eq("bp_released", 32'(busy_w[0]), 32'd0);
    send(2, 0); send(3, 1);
    drain();

    // Reset mid-frame discards it.
    send(4, 0); send(4, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_first = 1'b1;
    check_cleared("midrst");
    send(1, 1);
    drain();

    // Long frame: count saturates on the narrow-counter instance.
    for (int i = 0; i < 6; i++) send(1, (i == 5));
    drain();

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      expect_eq($sformatf("pending[%0d]", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
